// File: rtl/mdu_issue_arb.sv
// rtl/mdu_issue_arb.sv - oldest-first arbiter feeding the shared MDU through a one-entry output stage
module mdu_issue_arb #(
  parameter int N_REQ     = 4,
  parameter int ROB_DEPTH = 16,
  parameter int ROB_PTR_W = $clog2(ROB_DEPTH),
  parameter int TAG_W     = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [ROB_PTR_W-1:0]       rob_head,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*3-1:0]         req_opc,
  input  logic [N_REQ*32-1:0]        req_src1,
  input  logic [N_REQ*32-1:0]        req_src2,
  input  logic [N_REQ*TAG_W-1:0]     req_tag,
  input  logic [N_REQ*ROB_PTR_W-1:0] req_inst_id,
  output logic [N_REQ-1:0]           req_grant,
  output logic                       mdu_req,
  input  logic                       mdu_rdy,
  output logic [2:0]                 mdu_opc,
  output logic [31:0]                mdu_src1,
  output logic [31:0]                mdu_src2,
  output logic [TAG_W-1:0]           mdu_tag,
  output logic [ROB_PTR_W-1:0]       mdu_inst_id,
  output logic [31:0]                issue_cnt
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0]     win_idx;
  logic                 win_found;
  logic [ROB_PTR_W-1:0] win_age;
  logic [ROB_PTR_W-1:0] age;
  logic                 load;
  logic                 grant_any;
  logic                 xfer;

  // Age is distance from rob_head modulo the ROB; strict '<' keeps the lowest index on ties.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_age   = '0;
    age       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      age = req_inst_id[i*ROB_PTR_W +: ROB_PTR_W] - rob_head;
      if (req_valid[i] && (!win_found || age < win_age)) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
        win_age   = age;
      end
    end
  end

  assign load      = ~flush & (~mdu_req | mdu_rdy);
  assign grant_any = load & win_found & ~rst;
  assign xfer      = mdu_req & mdu_rdy & ~flush;

  always_comb begin
    req_grant = '0;
    if (grant_any) req_grant[win_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mdu_req     <= 1'b0;
      mdu_opc     <= '0;
      mdu_src1    <= '0;
      mdu_src2    <= '0;
      mdu_tag     <= '0;
      mdu_inst_id <= '0;
      issue_cnt   <= '0;
    end else begin
      if (flush) begin
        mdu_req <= 1'b0;
      end else if (grant_any) begin
        mdu_req     <= 1'b1;
        mdu_opc     <= req_opc[win_idx*3 +: 3];
        mdu_src1    <= req_src1[win_idx*32 +: 32];
        mdu_src2    <= req_src2[win_idx*32 +: 32];
        mdu_tag     <= req_tag[win_idx*TAG_W +: TAG_W];
        mdu_inst_id <= req_inst_id[win_idx*ROB_PTR_W +: ROB_PTR_W];
      end else if (mdu_req && mdu_rdy) begin
        mdu_req <= 1'b0;
      end
      if (xfer) issue_cnt <= issue_cnt + 32'd1;
    end
  end

  a_grant_onehot: assert property (@(posedge clk) $onehot0(req_grant));
  a_no_grant_flush: assert property (@(posedge clk) flush |-> (req_grant == '0));
  a_payload_stable: assert property (@(posedge clk)
    (!rst && mdu_req && !mdu_rdy) |=> $stable({mdu_opc, mdu_src1, mdu_src2, mdu_tag, mdu_inst_id}));

endmodule

// File: tb/tb_mdu_issue_arb.sv
// tb/tb_mdu_issue_arb.sv - self-checking bench for mdu_issue_arb against an age-ordered reference model
module tb_mdu_issue_arb;
  localparam int N = 4;
  localparam int D = 16;

  logic         clk, rst, flush, mdu_rdy;
  logic [3:0]   rob_head;
  logic [3:0]   req_valid;
  logic [11:0]  req_opc;
  logic [127:0] req_src1, req_src2;
  logic [23:0]  req_tag;
  logic [15:0]  req_inst_id;
  logic [3:0]   req_grant;
  logic         mdu_req;
  logic [2:0]   mdu_opc;
  logic [31:0]  mdu_src1, mdu_src2, issue_cnt;
  logic [5:0]   mdu_tag;
  logic [3:0]   mdu_inst_id;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic         m_req;
  logic [2:0]   m_opc;
  logic [31:0]  m_src1, m_src2, m_cnt;
  logic [5:0]   m_tag;
  logic [3:0]   m_id;
  logic [3:0]   exp_grant;
  int           exp_win;

  mdu_issue_arb #(.N_REQ(N), .ROB_DEPTH(D), .ROB_PTR_W(4), .TAG_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush), .rob_head(rob_head),
    .req_valid(req_valid), .req_opc(req_opc), .req_src1(req_src1), .req_src2(req_src2),
    .req_tag(req_tag), .req_inst_id(req_inst_id), .req_grant(req_grant),
    .mdu_req(mdu_req), .mdu_rdy(mdu_rdy), .mdu_opc(mdu_opc), .mdu_src1(mdu_src1),
    .mdu_src2(mdu_src2), .mdu_tag(mdu_tag), .mdu_inst_id(mdu_inst_id), .issue_cnt(issue_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_req(input int i, input bit v, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] t, input logic [3:0] id);
    req_valid[i]         = v;
    req_opc[3*i +: 3]    = o;
    req_src1[32*i +: 32] = a;
    req_src2[32*i +: 32] = b;
    req_tag[6*i +: 6]    = t;
    req_inst_id[4*i +: 4] = id;
  endtask

  // Winner = minimum of (age * N + index) over valid requesters.
  task automatic predict();
    int best;
    int key;
    best = -1;
    exp_grant = 4'b0;
    exp_win = -1;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i]) begin
        key = ((int'(req_inst_id[4*i +: 4]) - int'(rob_head) + D) % D) * N + i;
        if (best < 0 || key < best) best = key;
      end
    end
    if (!rst && !flush && (!m_req || mdu_rdy) && best >= 0) begin
      exp_win = best % N;
      exp_grant[exp_win] = 1'b1;
    end
  endtask

  task automatic tick();
    predict();
    if (rst) begin
      m_req = 0; m_opc = 0; m_src1 = 0; m_src2 = 0; m_tag = 0; m_id = 0; m_cnt = 0;
    end else begin
      if (m_req && mdu_rdy && !flush) m_cnt = m_cnt + 1;
      if (flush) m_req = 0;
      else if (exp_win >= 0) begin
        m_req  = 1;
        m_opc  = req_opc[3*exp_win +: 3];
        m_src1 = req_src1[32*exp_win +: 32];
        m_src2 = req_src2[32*exp_win +: 32];
        m_tag  = req_tag[6*exp_win +: 6];
        m_id   = req_inst_id[4*exp_win +: 4];
      end else if (m_req && mdu_rdy) m_req = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0; flush = 0; mdu_rdy = 1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; mdu_rdy = 1; rob_head = 0;
    for (int i = 0; i < N; i++) set_req(i, 1, 3'(i), 32'(i), 32'(i), 6'(i), 4'(i));
    tick(); tick();
    n_checks++; if (req_grant !== 4'b0) begin n_fail++; $display("FAIL reset_grant got %b exp 0000", req_grant); end
    n_checks++; if (mdu_req !== 1'b0) begin n_fail++; $display("FAIL reset_mdu_req got %b exp 0", mdu_req); end
    n_checks++; if ({mdu_opc, mdu_src1, mdu_src2, mdu_tag, mdu_inst_id} !== '0)
      begin n_fail++; $display("FAIL reset_payload got %h exp 0", {mdu_opc, mdu_src1, mdu_src2, mdu_tag, mdu_inst_id}); end
    n_checks++; if (issue_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", issue_cnt); end
    req_valid = '0;
    rst = 0;
    tick();
  endtask

  task automatic test_single();
    rob_head = 0; mdu_rdy = 1;
    set_req(2, 1, 3'd5, 32'hA5A5_0001, 32'h1234_5678, 6'd9, 4'd5);
    #1;
    n_checks++; if (req_grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant got %b exp 0100", req_grant); end
    tick();
    req_valid = '0;
    n_checks++; if (mdu_req !== 1'b1 || mdu_inst_id !== 4'd5)
      begin n_fail++; $display("FAIL single_out got req=%b id=%0d exp req=1 id=5", mdu_req, mdu_inst_id); end
    n_checks++; if (mdu_src1 !== 32'hA5A5_0001 || mdu_src2 !== 32'h1234_5678 || mdu_opc !== 3'd5 || mdu_tag !== 6'd9)
      begin n_fail++; $display("FAIL single_payload got %h %h %0d %0d", mdu_src1, mdu_src2, mdu_opc, mdu_tag); end
    tick();
    n_checks++; if (issue_cnt !== 32'd1 || mdu_req !== 1'b0)
      begin n_fail++; $display("FAIL single_cnt got cnt=%0d req=%b exp cnt=1 req=0", issue_cnt, mdu_req); end
  endtask

  task automatic test_age_wrap();
    int order [4] = '{3, 1, 2, 0};
    logic [3:0] ids [4] = '{4'd2, 4'd15, 4'd0, 4'd14};
    rob_head = 14; mdu_rdy = 1;
    for (int i = 0; i < N; i++) set_req(i, 1, 3'(i), 32'h100 + 32'(i), 32'h200 + 32'(i), 6'(i + 20), ids[i]);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (req_grant !== 4'(1 << order[k]))
        begin n_fail++; $display("FAIL age_wrap_grant%0d got %b exp %b", k, req_grant, 4'(1 << order[k])); end
      tick();
      req_valid[order[k]] = 1'b0;
      n_checks++; if (mdu_req !== 1'b1 || mdu_inst_id !== ids[order[k]])
        begin n_fail++; $display("FAIL age_wrap_out%0d got id=%0d exp %0d", k, mdu_inst_id, ids[order[k]]); end
    end
  endtask

  task automatic test_backpressure();
    logic [79:0] held;
    logic [31:0] cnt0;
    mdu_rdy = 0;
    set_req(0, 1, 3'd1, 32'h11, 32'h12, 6'd1, 4'd3);
    set_req(1, 1, 3'd2, 32'h21, 32'h22, 6'd2, 4'd7);
    set_req(2, 1, 3'd3, 32'h31, 32'h32, 6'd3, 4'd1);
    set_req(3, 1, 3'd4, 32'h41, 32'h42, 6'd4, 4'd9);
    held = {mdu_opc, mdu_src1, mdu_src2, mdu_tag, mdu_inst_id};
    cnt0 = issue_cnt;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if (req_grant !== 4'b0) begin n_fail++; $display("FAIL bp_grant%0d got %b exp 0000", k, req_grant); end
      tick();
      n_checks++; if (mdu_req !== 1'b1 || {mdu_opc, mdu_src1, mdu_src2, mdu_tag, mdu_inst_id} !== held)
        begin n_fail++; $display("FAIL bp_hold%0d got req=%b payload changed", k, mdu_req); end
    end
    mdu_rdy = 1;
    #1;
    n_checks++; if (req_grant !== 4'b0100) begin n_fail++; $display("FAIL bp_release_grant got %b exp 0100", req_grant); end
    tick();
    n_checks++; if (mdu_req !== 1'b1 || mdu_inst_id !== 4'd1 || mdu_src1 !== 32'h31 || issue_cnt !== cnt0 + 1)
      begin n_fail++; $display("FAIL bp_release_out got req=%b id=%0d cnt=%0d exp 1 1 %0d", mdu_req, mdu_inst_id, issue_cnt, cnt0 + 1); end
    idle(); idle();
  endtask

  task automatic test_flush();
    logic [31:0] cnt0;
    rob_head = 0; mdu_rdy = 1;
    set_req(0, 1, 3'd6, 32'hF0, 32'hF1, 6'd5, 4'd4);
    tick();
    set_req(1, 1, 3'd7, 32'hE0, 32'hE1, 6'd6, 4'd2);
    cnt0 = issue_cnt;
    flush = 1;
    #1;
    n_checks++; if (req_grant !== 4'b0) begin n_fail++; $display("FAIL flush_grant got %b exp 0000", req_grant); end
    tick();
    flush = 0;
    n_checks++; if (mdu_req !== 1'b0 || issue_cnt !== cnt0)
      begin n_fail++; $display("FAIL flush_drop got req=%b cnt=%0d exp 0 %0d", mdu_req, issue_cnt, cnt0); end
    #1;
    n_checks++; if (req_grant !== 4'b0010) begin n_fail++; $display("FAIL flush_resume got %b exp 0010", req_grant); end
    tick();
    n_checks++; if (mdu_req !== 1'b1 || mdu_inst_id !== 4'd2)
      begin n_fail++; $display("FAIL flush_resume_out got req=%b id=%0d exp 1 2", mdu_req, mdu_inst_id); end
    idle(); idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] cnt0;
    rob_head = 4'd8; mdu_rdy = 1;
    cnt0 = issue_cnt;
    for (int k = 0; k < 8; k++) begin
      set_req(0, 1, 3'(k), 32'hC000 + 32'(k), 32'hD000 + 32'(k), 6'(k), 4'(8 + k));
      #1;
      n_checks++; if (req_grant !== 4'b0001) begin n_fail++; $display("FAIL b2b_grant%0d got %b exp 0001", k, req_grant); end
      tick();
      n_checks++; if (mdu_req !== 1'b1 || mdu_src1 !== 32'hC000 + 32'(k))
        begin n_fail++; $display("FAIL b2b_out%0d got req=%b src1=%h exp 1 %h", k, mdu_req, mdu_src1, 32'hC000 + 32'(k)); end
    end
    idle();
    n_checks++; if (issue_cnt !== cnt0 + 8 || mdu_req !== 1'b0)
      begin n_fail++; $display("FAIL b2b_cnt got %0d exp %0d", issue_cnt, cnt0 + 8); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom_range(0, 1)), 3'($urandom), $urandom, $urandom, 6'($urandom), 4'($urandom));
      rob_head = 4'($urandom);
      mdu_rdy  = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      #1;
      predict();
      n_checks++; if (req_grant !== exp_grant)
        begin n_fail++; $display("FAIL rand_grant c%0d got %b exp %b", c, req_grant, exp_grant); end
      tick();
      n_checks++; if (mdu_req !== m_req)
        begin n_fail++; $display("FAIL rand_req c%0d got %b exp %b", c, mdu_req, m_req); end
      if (m_req) begin
        n_checks++; if ({mdu_opc, mdu_src1, mdu_src2, mdu_tag, mdu_inst_id} !== {m_opc, m_src1, m_src2, m_tag, m_id})
          begin n_fail++; $display("FAIL rand_payload c%0d got id=%0d exp id=%0d", c, mdu_inst_id, m_id); end
      end
      n_checks++; if (issue_cnt !== m_cnt)
        begin n_fail++; $display("FAIL rand_cnt c%0d got %0d exp %0d", c, issue_cnt, m_cnt); end
    end
    idle(); idle();
  endtask

  task automatic test_reset_mid_op();
    rob_head = 0; mdu_rdy = 0;
    set_req(3, 1, 3'd2, 32'h77, 32'h88, 6'd33, 4'd6);
    tick();
    n_checks++; if (mdu_req !== 1'b1) begin n_fail++; $display("FAIL midrst_setup got req=%b exp 1", mdu_req); end
    rst = 1; mdu_rdy = 1;
    #1;
    n_checks++; if (req_grant !== 4'b0) begin n_fail++; $display("FAIL midrst_grant got %b exp 0000", req_grant); end
    tick();
    n_checks++; if (mdu_req !== 1'b0 || issue_cnt !== 32'd0 || mdu_inst_id !== 4'd0)
      begin n_fail++; $display("FAIL midrst_out got req=%b cnt=%0d id=%0d exp 0 0 0", mdu_req, issue_cnt, mdu_inst_id); end
    rst = 0;
    idle();
  endtask

  initial begin
    rst = 1; flush = 0; mdu_rdy = 0; rob_head = 0;
    req_valid = '0; req_opc = '0; req_src1 = '0; req_src2 = '0; req_tag = '0; req_inst_id = '0;
    m_req = 0; m_opc = 0; m_src1 = 0; m_src2 = 0; m_tag = 0; m_id = 0; m_cnt = 0;
    exp_grant = 0; exp_win = -1;
    #2;
    test_reset();
    test_single();
    test_age_wrap();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_issue_arb.md
Name: mdu_issue_arb

Overview:
- Shares the single multiply/divide unit (MDU) between N_REQ reservation-station requesters.
- Each cycle, selects the oldest ready MDU op by ROB age relative to rob_head.
- Registers the selected op in a one-entry output stage that drives the MDU request/ready handshake.
- Sits between the MDU reservation stations and the MDU; supports pipeline flush.

Parameters:
N_REQ, 4, number of requesters (2..8)
ROB_DEPTH, 16, ROB entries; power of two
ROB_PTR_W, $clog2(ROB_DEPTH), inst_id / rob_head width
TAG_W, 6, physical destination tag width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  squash all held and in-progress selection this cycle
rob_head  in  ROB_PTR_W  current ROB head index (oldest instruction)
req_valid  in  N_REQ  requester i holds a ready MDU op
req_opc  in  N_REQ*3  per-requester MDU opcode (mdu_op_* encoding), slice i at [3i+:3]
req_src1  in  N_REQ*32  operand 1, slice i at [32i+:32]
req_src2  in  N_REQ*32  operand 2
req_tag  in  N_REQ*TAG_W  destination tag
req_inst_id  in  N_REQ*ROB_PTR_W  ROB index
req_grant  out  N_REQ  one-hot accept; requester i's op is taken this cycle
mdu_req  out  1  output stage valid
mdu_rdy  in  1  MDU accepts this cycle
mdu_opc  out  3  held opcode
mdu_src1  out  32  held operand 1
mdu_src2  out  32  held operand 2
mdu_tag  out  TAG_W  held tag
mdu_inst_id  out  ROB_PTR_W  held ROB index
issue_cnt  out  32  count of ops handed to MDU, wraps

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: mdu_req=0; mdu_opc, mdu_src1, mdu_src2, mdu_tag, mdu_inst_id, issue_cnt = 0; req_grant=0, held while rst=1.
- Age of requester i: (req_inst_id[i] - rob_head) mod ROB_DEPTH, computed in ROB_PTR_W bits; wraps naturally.
- Selection: among req_valid=1, the smallest age wins.
  - Tie (equal inst_id, illegal but defined): lowest index wins.
  - Selection is combinational, in the same cycle as req_valid.
- Load enable: load = ~flush & (~mdu_req | mdu_rdy).
- Grant: req_grant[winner] = load & any(req_valid); otherwise 0. At most one bit is set.
  - req_grant depends combinationally on req_valid, rob_head and mdu_rdy.
  - Requesters must not make req_valid depend on req_grant.
- Output stage next state:
  - flush=1: mdu_req<=0; payload unchanged (don't care).
  - else if load and a grant is issued: mdu_req<=1; payload <= winner's opc/src1/src2/tag/inst_id.
  - else if mdu_req & mdu_rdy: mdu_req<=0.
  - else: hold. Payload is stable while mdu_req=1 & mdu_rdy=0.
- Throughput: back-to-back issue with no bubble when mdu_rdy=1 every cycle. A new op is loaded in the same cycle the held op transfers.
- Latency: requester grant -> mdu_req is 1 cycle.
- issue_cnt increments by 1 on each cycle with mdu_req & mdu_rdy & ~flush. Wraps from 0xFFFFFFFF to 0.
- Flush:
  - Drops the held op; no grant that cycle.
  - A concurrent mdu_req & mdu_rdy transfer is not counted.
  - The MDU itself is flushed separately.
- Boundary cases:
  - rob_head wrap: inst_id 1 with rob_head 14 has age 3; it beats inst_id 15 (age 1)? No: age 1 wins. Ordering is strictly modular.
  - No requests: req_grant=0; the output stage only drains.
  - mdu_rdy=0 with mdu_req=1: all grants held at 0; requests wait.
- Reset mid-operation: held op discarded; outputs return to reset values next edge.
- Assertions:
  - $onehot0(req_grant).
  - Payload stable while mdu_req & ~mdu_rdy.
  - No grant while flush.

Test Plan:
- Single request: req_valid=4'b0100, inst_id2=5, rob_head=0, mdu_rdy=1 -> req_grant=4'b0100 that cycle; next cycle mdu_req=1, mdu_inst_id=5, mdu_src1/src2 match; issue_cnt=1 after transfer.
- Age with wrap: rob_head=14, requesters 0..3 valid with inst_id 2, 15, 0, 14 -> grant order 3, 1, 2, 0 on four consecutive cycles (mdu_rdy=1, each requester drops valid after grant).
- Backpressure: mdu_req=1, mdu_rdy=0 for 5 cycles with req_valid=4'b1111 -> req_grant=0 throughout, payload unchanged; mdu_rdy=1 on cycle 6 -> oldest granted that same cycle, mdu_req stays 1 with new payload.
- Flush: held op present and mdu_rdy=1, flush=1 with req_valid=4'b0011 -> req_grant=0, issue_cnt unchanged, mdu_req=0 next cycle; grants resume the cycle after flush deasserts.
- Back-to-back streaming: 8 ops fed to requester 0 every cycle, mdu_rdy=1 -> mdu_req high for 8 consecutive cycles, issue_cnt=8, ops in input order.
- Reset mid-op: mdu_req=1 and rst=1 for one cycle -> mdu_req=0, issue_cnt=0, req_grant=0 while rst high.
